hazard_controller: RTL
======================

// Module: hazard_controller
// PURPOSE
//  Pipeline sequencer for the 5-stage core. Drives the execute-stage operand forwarding selects.
//  Detects load-use hazards and sequences branch/PC-write flushes.
//  Runs a multi-cycle multiply FSM that stalls F/D/E while the E-stage multiplier iterates.
//  Sits beside the datapath; all stage registers take their enable/flush from this block.
// PARAMETERS
//  MUL_LAT   4   total E-stage cycles of a multiply; legal 2..16
//  CNT_W     32  width of perf counters (used only with HAZARD_PERF_CNT_EN)
// PORTS
//  clk            in   1  core clock, rising edge
//  reset          in   1  synchronous, active-high
//  RA1D, RA2D     in   4  source regs of instruction in Decode
//  RA1E, RA2E     in   4  source regs of instruction in Execute
//  WA3E,WA3M,WA3W in   4  destination regs in E, M, W
//  RegWriteE/M/W  in   1  destination write enable per stage
//  MemtoRegE      in   1  instruction in E is a load
//  MulStartE      in   1  valid multiply in E (already condition-passed)
//  BranchTakenE   in   1  branch resolved taken in E
//  PCWrPendingF   in   1  PC-writing (non-branch) instr in D, E or M
//  PCSrcW         in   1  PC-writing instr retiring in W
//  ForwardAE      out  2  Op1 select: 00 RD1E, 01 ResultW, 10 ALUResultM
//  ForwardBE      out  2  Op2/WriteData select, same encoding
//  StallF,StallD  out  1  hold PC / IF-ID register
//  StallE         out  1  hold ID-EX register
//  FlushD,FlushE  out  1  bubble into IF-ID / ID-EX register
//  FlushM         out  1  bubble into EX-MEM register
//  MulBusy        out  1  multiply FSM not idle
//  MulDoneE       out  1  final multiply cycle; result valid on ALUResultE
// BEHAVIOUR
//  Forwarding (comb.): ForwardAE=10 if RegWriteM & WA3M==RA1E; else 01 if RegWriteW & WA3W==RA1E; else 00.
//   ForwardBE uses RA2E identically. M beats W on a double match. R15 is never forwarded (returns 00).
//  ldStall = MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D).
//   Gives StallF=StallD=1 and FlushE=1 for one cycle. Next cycle forwarding selects 01.
//  Branch: BranchTakenE -> FlushD=FlushE=1 in the same cycle; StallD masked by the flush.
//  PCWrPendingF -> StallF=1, FlushD=1. PCSrcW -> StallF=0, FlushD=1.
//  Mul FSM: IDLE, BUSY. Counter cnt is $clog2(MUL_LAT) bits wide.
//   IDLE & MulStartE & ~BranchTakenE -> BUSY, cnt<=MUL_LAT-2.
//    The same cycle asserts StallF/StallD/StallE=1 and FlushM=1.
//   BUSY & cnt!=0 -> cnt<=cnt-1; stalls and FlushM held at 1.
//   BUSY & cnt==0 -> MulDoneE=1 and stalls released (E/M captures result) -> IDLE.
//   Multiply occupies E for exactly MUL_LAT cycles; MulBusy=1 in BUSY only.
//  Priority, same cycle: reset > BranchTakenE > mul stall > ldStall > PC-pending.
//   BranchTakenE together with MulStartE: the multiply is not started.
//   ldStall while BUSY is held off until MulDoneE, then evaluated normally.
//  Forwarding selects stay valid during BUSY (operands held via StallE).
//  Reset values: FSM=IDLE, cnt=0. Stall/MulBusy/MulDoneE=0.
//   FlushD=FlushE=FlushM=1 while reset is high; Forward*E=00.
//   Reset mid-BUSY aborts the multiply; no MulDoneE is emitted.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs StallCount[CNT_W] and FlushCount[CNT_W].
//   StallCount increments on any cycle with StallF=1.
//   FlushCount increments on any cycle with FlushD|FlushE=1.
//   Both counters saturate at all-ones and clear on reset.
//  HAZARD_PERF_CNT_EN undefined: those ports and registers are absent.
// TESTING
//  RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10 (M priority).
//  RA2E=5, WA3W=5, RegWriteW=1, no M match -> ForwardBE=01; RA2E=15 -> 00.
//  Load WA3E=2, MemtoRegE=1, RA1D=2 -> one cycle StallF=StallD=FlushE=1, then ForwardAE=01.
//  MUL_LAT=4, MulStartE=1 -> stalls for 3 cycles, MulDoneE on the 4th, MulBusy cleared next.
//  MulStartE=1 with BranchTakenE=1 -> FlushD=FlushE=1, MulBusy stays 0.
//  reset=1 during BUSY, cnt=1 -> next cycle IDLE with no MulDoneE; perf counters=0 (macro on).

Source files
------------

// File: rtl/hazard_controller.sv
// ============================================================================
// hazard_controller : forwarding, load-use / branch / PC-write sequencing and a
//                     multi-cycle multiply stall FSM for the 5-stage core.
// Optional macro    : HAZARD_PERF_CNT_EN adds StallCount / FlushCount outputs.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module hazard_controller #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MulStartE,
  input  logic             BranchTakenE,
  input  logic             PCWrPendingF,
  input  logic             PCSrcW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MulBusy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
`endif
  output logic             MulDoneE
);

  localparam int              CW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(MUL_LAT - 2);
  localparam logic [0:0]      S_IDLE   = 1'b0;
  localparam logic [0:0]      S_BUSY   = 1'b1;

  generate
    if (MUL_LAT < 2 || MUL_LAT > 16 || CNT_W < 1) begin : g_bad_params
      $error("hazard_controller: MUL_LAT must be 2..16 and CNT_W >= 1");
    end
  endgenerate

  logic [0:0]    state;
  logic [0:0]    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          mul_start;
  logic          mul_hold;
  logic          mul_stall;
  logic          ld_stall;

  // R15 is the PC and is never supplied from the forwarding network.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic       wr_m,
                                         input logic [3:0] wa_m,
                                         input logic       wr_w,
                                         input logic [3:0] wa_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != 4'd15) begin
      if (wr_m && (wa_m == ra))      sel = 2'b10;
      else if (wr_w && (wa_w == ra)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (MulStartE && !BranchTakenE) begin
          state_next = S_BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      S_BUSY: begin
        if (cnt != '0) cnt_next = cnt - CW'(1);
        else           state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign mul_start = (state == S_IDLE) && MulStartE && !BranchTakenE;
  assign mul_hold  = (state == S_BUSY) && (cnt != '0);
  assign mul_stall = mul_start || mul_hold;
  assign ld_stall  = MemtoRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));

  // Single priority chain: reset > branch > multiply > load-use > PC write.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    MulBusy   = (state == S_BUSY);
    MulDoneE  = (state == S_BUSY) && (cnt == '0);
    ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
    if (reset) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushM    = 1'b1;
      MulBusy   = 1'b0;
      MulDoneE  = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else if (BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (mul_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (ld_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (PCWrPendingF || PCSrcW) begin
      FlushD = 1'b1;
      StallF = PCWrPendingF && !PCSrcW;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && (StallCount != '1))
        StallCount <= StallCount + CNT_W'(1);
      if ((FlushD || FlushE) && (FlushCount != '1))
        FlushCount <= FlushCount + CNT_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire
